mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one external memory/MMIO bus between the cpu data/instruction port and a DMA/loader master.
- Sits between cpu (mem_re/mem_we/mem_addr/mem_wd/mem_rd/unit/fault signals) and the memory system.
- Round-robin arbitration, registered bus handshake, alignment checking, and fault reporting back to the cpu.

Parameters:
- TIMEOUT_CYCLES, 255: bus_ack/bus_err wait limit per transfer. Range 1..65535. Used only with MEM_ARB_TIMEOUT_EN.
- CPU_FIRST, 1: reset value of the round-robin priority bit. 1 = cpu wins the first tie.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_re  in  1  cpu read request, level, held until cpu_stall low
- cpu_we  in  1  cpu write request, level
- cpu_addr  in  32  cpu byte address
- cpu_wd  in  32  cpu write data
- cpu_unit  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved
- cpu_rd  out  32  read data, valid while cpu_stall=0 in response cycle
- cpu_stall  out  1  cpu must hold request and state
- cpu_access_fault  out  1  bus error/timeout/reserved unit, one cycle
- cpu_addr_misaligned  out  1  misaligned cpu request, combinational
- dma_req  in  1  DMA request, held until dma_done
- dma_we  in  1  DMA write (0 = read)
- dma_addr  in  32  DMA byte address
- dma_wd  in  32  DMA write data
- dma_unit  in  2  DMA access size, same encoding as cpu_unit
- dma_done  out  1  one-cycle completion pulse
- dma_rd  out  32  DMA read data, valid with dma_done
- dma_err  out  1  fault flag, valid with dma_done
- bus_req  out  1  bus transfer request, registered
- bus_we  out  1  bus write, registered
- bus_addr  out  32  bus address, registered
- bus_wd  out  32  bus write data, registered
- bus_unit  out  2  bus access size, registered
- bus_ack  in  1  bus transfer complete; bus_rd valid
- bus_rd  in  32  bus read data
- bus_err  in  1  bus error; completes transfer

Behaviour:

States: IDLE, CPU_BUS, CPU_RESP, DMA_BUS, DMA_RESP.

Reset (reset=0, asynchronous):
- State goes to IDLE; priority bit = CPU_FIRST.
- All registered bus_* outputs, dma_done, dma_err, cpu_access_fault, and the timeout counter go to 0.
- cpu_rd and dma_rd go to 0.
- bus_req drops immediately, even mid-transfer. No response is issued for the aborted transfer.

Request validity and alignment:
- cpu request = cpu_re|cpu_we. cpu_re and cpu_we both high: treated as a write.
- Misaligned: unit 1 with addr[0]=1, or unit 2 with addr[1:0]!=0.
- cpu_addr_misaligned = request & misaligned, combinational in any state.
- A misaligned cpu request never reaches the bus and gives cpu_stall=0 the same cycle.
- Misaligned DMA requests are not rejected at the arbiter; they pass to the bus.
- Unit 3 from the cpu: in IDLE, go to CPU_RESP without a bus transfer; cpu_access_fault=1 there.
- Unit 3 from DMA: in IDLE, go to DMA_RESP without a bus transfer; dma_err=1 there.

IDLE arbitration:
- Only the cpu valid (aligned) → CPU_BUS. Only dma_req → DMA_BUS.
- Both: priority bit 1 → CPU_BUS, 0 → DMA_BUS.
- On entry to *_BUS, the winner's addr/wd/unit/we are latched into the bus_* registers and bus_req=1 next cycle.

*_BUS states:
- bus_* outputs are held stable.
- On bus_ack or bus_err, bus_rd and bus_err are latched, bus_req drops, and the state goes to *_RESP.

*_RESP states (one cycle):
- CPU_RESP: cpu_stall=0, cpu_rd = latched data, cpu_access_fault = latched err. Then IDLE; priority bit ← 0.
- DMA_RESP: dma_done=1, dma_rd, dma_err. Then IDLE; priority bit ← 1.

cpu_stall:
- cpu_stall = cpu request & !misaligned & state!=CPU_RESP.
- Minimum cpu latency is 3 cycles: IDLE, CPU_BUS with ack, CPU_RESP.

Cross-path isolation:
- Requests arriving while the other master owns the bus wait in IDLE arbitration.
- Dropping dma_req mid-transfer has no effect; the transfer completes and dma_done still pulses.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to *_BUS and increments each BUS cycle without ack/err. When it reaches TIMEOUT_CYCLES:
  - bus_req drops;
  - the state goes to *_RESP with err=1 and data=0;
  - a late bus_ack in IDLE is ignored.
- Undefined: no counter; *_BUS waits indefinitely for bus_ack/bus_err.

Test Plan:
1. After reset, cpu_re=1, addr=0x100, unit=2; bus_ack in the first CPU_BUS cycle with bus_rd=0xDEADBEEF → bus_req high 1 cycle, cpu_stall low on cycle 3, cpu_rd=0xDEADBEEF.
2. cpu_re and dma_req rise together twice in sequence → first grant to cpu (CPU_FIRST=1), then DMA, then cpu again. dma_done pulses once per transfer.
3. cpu_we, unit=2, addr=0x102 → cpu_addr_misaligned=1 same cycle, cpu_stall=0, bus_req never asserted.
4. DMA read, bus_err=1 after 4 wait cycles → dma_done=1, dma_err=1, dma_rd=0 latched value; next cpu access unaffected.
5. reset pulled low during CPU_BUS with bus_req=1 → bus_req=0 asynchronously, state IDLE, no cpu_access_fault. A new cpu request after release completes normally.
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no bus_ack → cpu_access_fault=1 in the cycle after the 8th wait cycle; a late bus_ack is ignored. Without the macro, the same stimulus keeps cpu_stall=1 for 100+ cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one registered memory bus between the cpu port and a DMA master.
// Optional transfer watchdog: define MEM_ARB_TIMEOUT_EN to bound each transfer to TIMEOUT_CYCLES wait cycles.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          CPU_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    input  logic [1:0]  cpu_unit,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    output logic        cpu_access_fault,
    output logic        cpu_addr_misaligned,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wd,
    input  logic [1:0]  dma_unit,
    output logic        dma_done,
    output logic [31:0] dma_rd,
    output logic        dma_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    output logic [1:0]  bus_unit,
    input  logic        bus_ack,
    input  logic [31:0] bus_rd,
    input  logic        bus_err
);

    typedef enum logic [2:0] {IDLE, CPU_BUS, CPU_RESP, DMA_BUS, DMA_RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    function automatic logic is_misaligned(input logic [1:0] unit, input logic [1:0] addr_lo);
        return ((unit == 2'd1) && addr_lo[0]) || ((unit == 2'd2) && (addr_lo != 2'd0));
    endfunction

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wd_q, bus_wd_d;
    logic [1:0]  bus_unit_q, bus_unit_d;
    logic        err_q, err_d;
    logic [31:0] cpu_rd_q, cpu_rd_d;
    logic [31:0] dma_rd_q, dma_rd_d;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
`endif

    logic cpu_req, cpu_mis, cpu_valid;

    assign cpu_req   = cpu_re | cpu_we;
    assign cpu_mis   = is_misaligned(cpu_unit, cpu_addr[1:0]);
    assign cpu_valid = cpu_req & ~cpu_mis;

    assign cpu_addr_misaligned = cpu_req & cpu_mis;
    assign cpu_stall           = cpu_valid & (state_q != CPU_RESP);
    assign cpu_access_fault    = (state_q == CPU_RESP) & err_q;
    assign cpu_rd              = cpu_rd_q;
    assign dma_done            = (state_q == DMA_RESP);
    assign dma_err             = (state_q == DMA_RESP) & err_q;
    assign dma_rd              = dma_rd_q;
    assign bus_req             = bus_req_q;
    assign bus_we              = bus_we_q;
    assign bus_addr            = bus_addr_q;
    assign bus_wd              = bus_wd_q;
    assign bus_unit            = bus_unit_q;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        bus_req_d  = bus_req_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_wd_d   = bus_wd_q;
        bus_unit_d = bus_unit_q;
        err_d      = err_q;
        cpu_rd_d   = cpu_rd_q;
        dma_rd_d   = dma_rd_q;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                // A simultaneous read+write from the cpu is issued as a write.
                if (cpu_valid && (!dma_req || prio_q)) begin
                    if (cpu_unit == 2'd3) begin
                        state_d  = CPU_RESP;
                        err_d    = 1'b1;
                        cpu_rd_d = '0;
                    end else begin
                        state_d    = CPU_BUS;
                        bus_req_d  = 1'b1;
                        bus_we_d   = cpu_we;
                        bus_addr_d = cpu_addr;
                        bus_wd_d   = cpu_wd;
                        bus_unit_d = cpu_unit;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_d      = '0;
`endif
                    end
                end else if (dma_req) begin
                    if (dma_unit == 2'd3) begin
                        state_d  = DMA_RESP;
                        err_d    = 1'b1;
                        dma_rd_d = '0;
                    end else begin
                        state_d    = DMA_BUS;
                        bus_req_d  = 1'b1;
                        bus_we_d   = dma_we;
                        bus_addr_d = dma_addr;
                        bus_wd_d   = dma_wd;
                        bus_unit_d = dma_unit;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_d      = '0;
`endif
                    end
                end
            end
            CPU_BUS, DMA_BUS: begin
                if (bus_ack || bus_err) begin
                    bus_req_d = 1'b0;
                    err_d     = bus_err;
                    if (state_q == CPU_BUS) begin
                        cpu_rd_d = bus_rd;
                        state_d  = CPU_RESP;
                    end else begin
                        dma_rd_d = bus_rd;
                        state_d  = DMA_RESP;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    // Watchdog expiry completes the transfer as an error with zero data.
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == CPU_BUS) begin
                        cpu_rd_d = '0;
                        state_d  = CPU_RESP;
                    end else begin
                        dma_rd_d = '0;
                        state_d  = DMA_RESP;
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            CPU_RESP: begin
                state_d = IDLE;
                prio_d  = 1'b0;
            end
            DMA_RESP: begin
                state_d = IDLE;
                prio_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prio_q     <= CPU_FIRST;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_wd_q   <= '0;
            bus_unit_q <= '0;
            err_q      <= 1'b0;
            cpu_rd_q   <= '0;
            dma_rd_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            bus_req_q  <= bus_req_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_wd_q   <= bus_wd_d;
            bus_unit_q <= bus_unit_d;
            err_q      <= err_d;
            cpu_rd_q   <= cpu_rd_d;
            dma_rd_q   <= dma_rd_d;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule
